// File: rtl/wb_port_arb.sv
// Regfile write-port arbiter: pipeline writeback versus a small FIFO of mul/div results.
// A starvation counter forces a buffered result out by stalling the pipeline for one cycle.
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef REG_BUS
`define REG_BUS 31:0
`endif

module wb_port_arb #(
    parameter int STARVE_MAX = 4,
    parameter int LL_DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p_we_i,
    input  logic [`REG_ADDR_BUS] p_addr_i,
    input  logic [`REG_BUS]      p_data_i,
    output logic                 stall_o,
    input  logic                 ll_valid_i,
    output logic                 ll_ready_o,
    input  logic [`REG_ADDR_BUS] ll_addr_i,
    input  logic [`REG_BUS]      ll_data_i,
    output logic [1:0]           ll_pending_o,
    output logic                 rd_we_o,
    output logic [`REG_ADDR_BUS] rd_addr_o,
    output logic [`REG_BUS]      rd_data_o
);
    localparam int PW = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
    localparam int CW = $clog2(LL_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX) + 1;

    typedef enum logic {ARB = 1'b0, FORCE = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  rd_we_q, rd_we_d;
    logic [`REG_ADDR_BUS]  rd_addr_q, rd_addr_d;
    logic [`REG_BUS]       rd_data_q, rd_data_d;
    logic [`REG_ADDR_BUS]  fifo_addr_q [LL_DEPTH];
    logic [`REG_BUS]       fifo_data_q [LL_DEPTH];

    logic                  push, pop, grant_p, has_head;
    logic [`REG_ADDR_BUS]  sel_addr;
    logic [`REG_BUS]       sel_data;

    // Ready and stall depend on registers only, so neither forms a path from the inputs.
    assign ll_ready_o   = (count_q < CW'(LL_DEPTH));
    assign stall_o      = (state_q == FORCE);
    assign ll_pending_o = 2'(count_q);
    assign rd_we_o      = rd_we_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_data_o    = rd_data_q;

    always_comb begin
        state_d  = state_q;
        grant_p  = 1'b0;
        pop      = 1'b0;
        has_head = (count_q != '0);
        push     = ll_valid_i && ll_ready_o;

        case (state_q)
            ARB: begin
                if (p_we_i) begin
                    grant_p = 1'b1;
                end else if (has_head) begin
                    pop = 1'b1;
                end
                if (has_head && !pop && (starve_q == SW'(STARVE_MAX - 1))) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                pop     = has_head;
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(LL_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(LL_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        starve_d = (!has_head || pop) ? '0 : starve_q + SW'(1);

        // Address 0 is consumed like any other entry but never reaches the regfile.
        sel_addr  = grant_p ? p_addr_i : fifo_addr_q[rd_ptr_q];
        sel_data  = grant_p ? p_data_i : fifo_data_q[rd_ptr_q];
        rd_we_d   = (grant_p || pop) && (sel_addr != '0);
        rd_addr_d = (grant_p || pop) ? sel_addr : rd_addr_q;
        rd_data_d = (grant_p || pop) ? sel_data : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset: a zero count makes every slot invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ll_addr_i;
            fifo_data_q[wr_ptr_q] <= ll_data_i;
        end
    end
endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb: a small grant model feeds an expected-write queue,
// and every rd_we_o pulse is popped and compared in order.
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef REG_BUS
`define REG_BUS 31:0
`endif

module tb_wb_port_arb;
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 p_we_i = 1'b0;
    logic [`REG_ADDR_BUS] p_addr_i = '0;
    logic [`REG_BUS]      p_data_i = '0;
    logic                 stall_o;
    logic                 ll_valid_i = 1'b0;
    logic                 ll_ready_o;
    logic [`REG_ADDR_BUS] ll_addr_i = '0;
    logic [`REG_BUS]      ll_data_i = '0;
    logic [1:0]           ll_pending_o;
    logic                 rd_we_o;
    logic [`REG_ADDR_BUS] rd_addr_o;
    logic [`REG_BUS]      rd_data_o;

    int checks = 0;
    int failures = 0;

    // Entries are {addr[4:0], data[31:0]}.
    logic [36:0] exp_q[$];
    logic [36:0] ll_model_q[$];
    logic [36:0] ll_src_q[$];

    logic        pipe_on = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;

    wb_port_arb #(.STARVE_MAX(4), .LL_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_we_i(p_we_i), .p_addr_i(p_addr_i), .p_data_i(p_data_i),
        .stall_o(stall_o),
        .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o),
        .ll_addr_i(ll_addr_i), .ll_data_i(ll_data_i),
        .ll_pending_o(ll_pending_o),
        .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample #1 after the edge; score any regfile write.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(rd_we_o), 64'(0));
            end else begin
                chk("write_entry", 64'({rd_addr_o, rd_data_o}), 64'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic push_exp(input logic [36:0] e);
        if (e[36:32] != 5'd0) exp_q.push_back(e);
    endtask

    // One cycle: drive sources, predict which entry wins the write port, clock.
    task automatic step();
        logic adv_p;
        adv_p = 1'b0;
        p_we_i   = pipe_on;
        p_addr_i = pipe_addr;
        p_data_i = pipe_data;
        if (stall_o === 1'b1) begin
            if (ll_model_q.size() == 0) chk("force_with_empty_fifo", 64'(stall_o), 64'(0));
            else push_exp(ll_model_q.pop_front());
        end else if (pipe_on) begin
            push_exp({pipe_addr, pipe_data});
            adv_p = 1'b1;
        end else if (ll_model_q.size() > 0) begin
            push_exp(ll_model_q.pop_front());
        end
        if (ll_src_q.size() > 0) begin
            ll_valid_i = 1'b1;
            {ll_addr_i, ll_data_i} = ll_src_q[0];
            if (ll_ready_o === 1'b1) ll_model_q.push_back(ll_src_q.pop_front());
        end else begin
            ll_valid_i = 1'b0;
        end
        tick();
        if (adv_p) pipe_data = pipe_data + 32'd1;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_rd_we", 64'(rd_we_o), 64'(0));
        chk("rst_rd_addr", 64'(rd_addr_o), 64'(0));
        chk("rst_rd_data", 64'(rd_data_o), 64'(0));
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_ready", 64'(ll_ready_o), 64'(1));
        chk("rst_pending", 64'(ll_pending_o), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_release_no_write", 64'(rd_we_o), 64'(0));

        // Pipeline-only write
        pipe_on = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hA5A5_0001;
        step();
        chk("pipe_we", 64'(rd_we_o), 64'(1));
        chk("pipe_addr", 64'(rd_addr_o), 64'(5));
        chk("pipe_data", 64'(rd_data_o), 64'hA5A5_0001);
        chk("pipe_stall", 64'(stall_o), 64'(0));
        pipe_on = 1'b0;
        step();
        chk("idle_we", 64'(rd_we_o), 64'(0));
        chk("idle_addr_hold", 64'(rd_addr_o), 64'(5));

        // Idle pop of one ll result
        ll_src_q.push_back({5'd7, 32'h0000_1234});
        step();
        chk("idle_pop_pending1", 64'(ll_pending_o), 64'(1));
        chk("idle_pop_no_write_yet", 64'(rd_we_o), 64'(0));
        step();
        chk("idle_pop_we", 64'(rd_we_o), 64'(1));
        chk("idle_pop_addr", 64'(rd_addr_o), 64'(7));
        chk("idle_pop_data", 64'(rd_data_o), 64'h1234);
        chk("idle_pop_pending0", 64'(ll_pending_o), 64'(0));

        // Starvation with the pipeline busy every cycle
        pipe_on = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h0000_0100;
        ll_src_q.push_back({5'd9, 32'h0000_BEEF});
        step();
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("starve_stall_c%0d", k), 64'(stall_o), 64'(k == 5));
            if (k == 6) chk("starve_pending0", 64'(ll_pending_o), 64'(0));
            step();
        end
        pipe_on = 1'b0;
        repeat (3) step();
        chk("starve_drained", 64'(exp_q.size()), 64'(0));

        // Full buffer under pipeline pressure
        pipe_on = 1'b1; pipe_addr = 5'd4; pipe_data = 32'h0000_0200;
        ll_src_q.push_back({5'd10, 32'h0000_AAAA});
        ll_src_q.push_back({5'd11, 32'h0000_BBBB});
        ll_src_q.push_back({5'd12, 32'h0000_CCCC});
        step();
        step();
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("full_ready_c%0d", k), 64'(ll_ready_o), 64'(0));
            chk($sformatf("full_pending_c%0d", k), 64'(ll_pending_o), 64'(2));
            step();
        end
        chk("full_ready_after_pop", 64'(ll_ready_o), 64'(1));
        repeat (20) step();
        pipe_on = 1'b0;
        repeat (3) step();
        chk("full_drained", 64'(exp_q.size()), 64'(0));
        chk("full_pending_end", 64'(ll_pending_o), 64'(0));

        // Address 0 from both sources
        pipe_on = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h0000_DEAD;
        step();
        pipe_on = 1'b0;
        chk("addr0_pipe_we", 64'(rd_we_o), 64'(0));
        ll_src_q.push_back({5'd0, 32'h0000_5555});
        step();
        chk("addr0_ll_pending1", 64'(ll_pending_o), 64'(1));
        step();
        chk("addr0_ll_pending0", 64'(ll_pending_o), 64'(0));
        step();
        chk("addr0_ll_we", 64'(rd_we_o), 64'(0));

        // Reset in the middle of FORCE with two entries buffered
        pipe_on = 1'b1; pipe_addr = 5'd6; pipe_data = 32'h0000_0300;
        ll_src_q.push_back({5'd13, 32'h0000_1313});
        ll_src_q.push_back({5'd14, 32'h0000_1414});
        for (int k = 0; k < 20 && stall_o !== 1'b1; k++) step();
        chk("mid_rst_reached_force", 64'(stall_o), 64'(1));
        chk("mid_rst_pending2", 64'(ll_pending_o), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 64'(stall_o), 64'(0));
        chk("mid_rst_pending", 64'(ll_pending_o), 64'(0));
        chk("mid_rst_we", 64'(rd_we_o), 64'(0));
        chk("mid_rst_ready", 64'(ll_ready_o), 64'(1));
        ll_model_q.delete();
        ll_src_q.delete();
        pipe_on = 1'b0;
        p_we_i = 1'b0;
        ll_valid_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) step();
        chk("mid_rst_no_write", 64'(rd_we_o), 64'(0));
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
